// File: rtl/dct_pkg.sv
// Shared widths, FSM state type and saturation bounds for the DCT coefficient accumulator.
package dct_pkg;

    localparam int DCT_VALUE_WIDTH = 32;
    localparam int DCT_PROD_WIDTH  = 2 * DCT_VALUE_WIDTH + 1;
    localparam int DCT_TERMS       = 4;
    localparam int DCT_FRAC_BITS   = 12;
    localparam int DCT_OUT_WIDTH   = 16;

    localparam int DCT_OUT_MAX = (1 << (DCT_OUT_WIDTH - 1)) - 1;
    localparam int DCT_OUT_MIN = -(1 << (DCT_OUT_WIDTH - 1));

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } dct_state_t;

endpackage

// File: rtl/round_sat.sv
// Round-half-up by FRAC_BITS, then clamp into a signed OUT_WIDTH coefficient.
module round_sat
    import dct_pkg::*;
#(
    parameter int IN_WIDTH  = DCT_PROD_WIDTH + 2,
    parameter int FRAC_BITS = DCT_FRAC_BITS,
    parameter int OUT_WIDTH = DCT_OUT_WIDTH
) (
    input  logic signed [IN_WIDTH-1:0]  din,
    output logic signed [OUT_WIDTH-1:0] dout
);

    // One guard bit so the rounding constant can never wrap the sum.
    localparam logic signed [IN_WIDTH:0] HALF =
        {{(IN_WIDTH - FRAC_BITS + 1){1'b0}}, 1'b1, {(FRAC_BITS - 1){1'b0}}};
    localparam logic signed [IN_WIDTH:0] MAX_EXT =
        {{(IN_WIDTH - OUT_WIDTH + 2){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] MIN_EXT =
        {{(IN_WIDTH - OUT_WIDTH + 2){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    logic signed [IN_WIDTH:0] rnd;
    logic signed [IN_WIDTH:0] shr;

    always_comb begin
        rnd = {din[IN_WIDTH-1], din} + HALF;
        shr = rnd >>> FRAC_BITS;
        if (shr > MAX_EXT)
            dout = MAX_EXT[OUT_WIDTH-1:0];
        else if (shr < MIN_EXT)
            dout = MIN_EXT[OUT_WIDTH-1:0];
        else
            dout = shr[OUT_WIDTH-1:0];
    end

endmodule

// File: rtl/dct_accum.sv
// Sums TERMS signed products per DCT coefficient and hands the rounded result downstream.
module dct_accum
    import dct_pkg::*;
#(
    parameter int VALUE_WIDTH = DCT_VALUE_WIDTH,
    parameter int PROD_WIDTH  = 2 * VALUE_WIDTH + 1,
    parameter int TERMS       = DCT_TERMS,
    parameter int FRAC_BITS   = DCT_FRAC_BITS,
    parameter int OUT_WIDTH   = DCT_OUT_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_aresetn,
    input  logic                  i_valid,
    input  logic [PROD_WIDTH-1:0] i_prod,
    input  logic                  i_clear,
    input  logic                  i_ready,
    output logic [OUT_WIDTH-1:0]  o_coef,
    output logic                  o_valid,
    output logic [2:0]            o_index,
    output logic                  o_busy,
    output logic                  o_overflow
);

    localparam int ACC_W = PROD_WIDTH + $clog2(TERMS);
    localparam int CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;

    dct_state_t       state;
    logic [ACC_W-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic [OUT_WIDTH-1:0] coef_next;
    logic             last_term;

    always_comb begin
        prod_ext  = {{(ACC_W - PROD_WIDTH){i_prod[PROD_WIDTH-1]}}, i_prod};
        sum       = acc + prod_ext;
        last_term = (state == ST_ACCUM) && (cnt == CNT_W'(TERMS - 1));
    end

    round_sat #(
        .IN_WIDTH (ACC_W),
        .FRAC_BITS(FRAC_BITS),
        .OUT_WIDTH(OUT_WIDTH)
    ) u_round_sat (
        .din (sum),
        .dout(coef_next)
    );

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state      <= ST_IDLE;
            acc        <= '0;
            cnt        <= '0;
            o_coef     <= '0;
            o_valid    <= 1'b0;
            o_index    <= '0;
            o_busy     <= 1'b0;
            o_overflow <= 1'b0;
        end else if (i_clear) begin
            state      <= ST_IDLE;
            acc        <= '0;
            cnt        <= '0;
            o_coef     <= '0;
            o_valid    <= 1'b0;
            o_index    <= '0;
            o_busy     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            // Handshake first; a completion in the same cycle re-asserts o_valid below.
            if (o_valid && i_ready) begin
                o_valid <= 1'b0;
                o_index <= o_index + 3'd1;
            end
            if (i_valid) begin
                if (state == ST_IDLE) begin
                    acc    <= prod_ext;
                    cnt    <= CNT_W'(1);
                    state  <= ST_ACCUM;
                    o_busy <= 1'b1;
                end else if (last_term) begin
                    acc    <= '0;
                    cnt    <= '0;
                    state  <= ST_IDLE;
                    o_busy <= 1'b0;
                    if (!o_valid || i_ready) begin
                        o_coef  <= coef_next;
                        o_valid <= 1'b1;
                    end else begin
                        o_overflow <= 1'b1;
                    end
                end else begin
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_dct_accum.sv
// Directed checks of dct_accum: rounding, saturation, index wrap, backpressure, clear and reset.
module tb_dct_accum;
    import dct_pkg::*;

    localparam int PW = DCT_PROD_WIDTH;

    logic          i_clk = 1'b0;
    logic          i_aresetn;
    logic          i_valid;
    logic [PW-1:0] i_prod;
    logic          i_clear;
    logic          i_ready;
    logic [15:0]   o_coef;
    logic          o_valid;
    logic [2:0]    o_index;
    logic          o_busy;
    logic          o_overflow;

    int total = 0;
    int bad   = 0;

    dct_accum #(
        .VALUE_WIDTH(DCT_VALUE_WIDTH),
        .TERMS      (DCT_TERMS),
        .FRAC_BITS  (DCT_FRAC_BITS),
        .OUT_WIDTH  (DCT_OUT_WIDTH)
    ) dut (
        .i_clk     (i_clk),
        .i_aresetn (i_aresetn),
        .i_valid   (i_valid),
        .i_prod    (i_prod),
        .i_clear   (i_clear),
        .i_ready   (i_ready),
        .o_coef    (o_coef),
        .o_valid   (o_valid),
        .o_index   (o_index),
        .o_busy    (o_busy),
        .o_overflow(o_overflow)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic push(input logic signed [PW-1:0] p);
        i_valid = 1'b1;
        i_prod  = p;
        tick();
        i_valid = 1'b0;
        i_prod  = '0;
    endtask

    task automatic coef4(input logic signed [PW-1:0] a, input logic signed [PW-1:0] b,
                         input logic signed [PW-1:0] c, input logic signed [PW-1:0] d,
                         input int gap);
        push(a);
        repeat (gap) tick();
        push(b);
        repeat (gap) tick();
        push(c);
        repeat (gap) tick();
        push(d);
    endtask

    task automatic chk_out(input string tag, input int coef, input int idx, input logic vld);
        chk({tag, "_coef"},  $signed(o_coef), coef);
        chk({tag, "_index"}, {29'd0, o_index}, idx);
        chk({tag, "_valid"}, {31'd0, o_valid}, {31'd0, vld});
    endtask

    initial begin
        logic signed [PW-1:0] big;
        big = 65'sd1 <<< 40;

        i_aresetn = 1'b0;
        i_valid   = 1'b0;
        i_prod    = '0;
        i_clear   = 1'b0;
        i_ready   = 1'b1;
        #2;
        chk_out("reset", 0, 0, 1'b0);
        chk("reset_busy", {31'd0, o_busy}, 0);
        chk("reset_ovf", {31'd0, o_overflow}, 0);
        tick();
        tick();
        i_aresetn = 1'b1;

        // Basic coefficient: 40960 rounds to 10
        push(65'sd4096);
        chk("busy_first_term", {31'd0, o_busy}, 1);
        push(65'sd8192);
        push(65'sd12288);
        push(65'sd16384);
        chk_out("basic", 10, 0, 1'b1);
        chk("basic_busy", {31'd0, o_busy}, 0);
        tick();
        chk_out("basic_accept", 10, 1, 1'b0);

        // Rounding boundaries and saturation
        coef4(65'sd2048, 65'sd0, 65'sd0, 65'sd0, 0);
        chk_out("round_up", 1, 1, 1'b1);
        tick();
        coef4(-65'sd2048, 65'sd0, 65'sd0, 65'sd0, 0);
        chk_out("round_neg", 0, 2, 1'b1);
        tick();
        coef4(big, big, big, big, 0);
        chk_out("sat_pos", DCT_OUT_MAX, 3, 1'b1);
        tick();
        coef4(-big, -big, -big, -big, 0);
        chk_out("sat_neg", DCT_OUT_MIN, 4, 1'b1);
        tick();

        // Index 5..7 then wrap to 0; gaps between terms must not change the result
        coef4(65'sd4096, 65'sd4096, 65'sd4096, 65'sd4096, 0);
        chk_out("idx5", 4, 5, 1'b1);
        tick();
        coef4(65'sd4096, 65'sd4096, 65'sd4096, 65'sd4096, 2);
        chk_out("idx6_gap", 4, 6, 1'b1);
        tick();
        coef4(65'sd4096, 65'sd4096, 65'sd4096, 65'sd4096, 1);
        chk_out("idx7_gap", 4, 7, 1'b1);
        tick();
        coef4(65'sd4096, 65'sd4096, 65'sd4096, 65'sd4096, 0);
        chk_out("idx_wrap", 4, 0, 1'b1);
        tick();
        chk("idx_after_wrap", {29'd0, o_index}, 1);

        // Backpressure: second completion is dropped
        i_ready = 1'b0;
        coef4(65'sd4096, 65'sd4096, 65'sd4096, 65'sd4096, 0);
        chk_out("hold_first", 4, 1, 1'b1);
        chk("hold_no_ovf", {31'd0, o_overflow}, 0);
        coef4(65'sd8192, 65'sd8192, 65'sd8192, 65'sd8192, 0);
        chk_out("drop_second", 4, 1, 1'b1);
        chk("drop_ovf", {31'd0, o_overflow}, 1);
        i_clear = 1'b1;
        tick();
        i_clear = 1'b0;
        chk_out("clear", 0, 0, 1'b0);
        chk("clear_ovf", {31'd0, o_overflow}, 0);

        // Completion coinciding with an accepted transfer
        coef4(65'sd4096, 65'sd4096, 65'sd4096, 65'sd4096, 0);
        chk_out("pend", 4, 0, 1'b1);
        push(65'sd8192);
        push(65'sd8192);
        push(65'sd8192);
        i_ready = 1'b1;
        push(65'sd8192);
        chk_out("accept_and_load", 8, 1, 1'b1);
        chk("accept_no_ovf", {31'd0, o_overflow}, 0);
        tick();
        chk_out("accept_drain", 8, 2, 1'b0);

        // Asynchronous reset mid-accumulation discards the partial sum
        push(65'sd400000);
        push(65'sd400000);
        #2;
        i_aresetn = 1'b0;
        #1;
        chk("async_rst_busy", {31'd0, o_busy}, 0);
        chk_out("async_rst", 0, 0, 1'b0);
        tick();
        i_aresetn = 1'b1;
        coef4(65'sd4096, 65'sd4096, 65'sd4096, 65'sd4096, 0);
        chk_out("post_reset", 4, 0, 1'b1);
        chk("post_reset_busy", {31'd0, o_busy}, 0);
        tick();

        // Clear beats a simultaneous final-term valid
        push(65'sd4096);
        push(65'sd4096);
        push(65'sd4096);
        i_clear = 1'b1;
        push(65'sd4096);
        i_clear = 1'b0;
        chk("clear_final_valid", {31'd0, o_valid}, 0);
        chk("clear_final_busy", {31'd0, o_busy}, 0);
        coef4(65'sd4096, 65'sd8192, 65'sd4096, 65'sd8192, 0);
        chk_out("after_clear", 6, 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dct_accum.md
DCT_ACCUM -- requirements
Module: dct_accum

Interface
REQ-001 The block SHALL have parameter VALUE_WIDTH, default 32: operand width of the upstream dsp_add stage.
REQ-002 The block SHALL have parameter PROD_WIDTH, default 2*VALUE_WIDTH+1: width of the incoming product.
REQ-003 The block SHALL have parameter TERMS, default 4: products summed per coefficient (butterfly-folded 8-point DCT).
REQ-004 The block SHALL have parameter FRAC_BITS, default 12: Q-format fraction bits of the cosine constants.
REQ-005 The block SHALL have parameter OUT_WIDTH, default 16: signed coefficient output width.
REQ-006 Port i_clk, input, 1 bit: single clock; the block SHALL use one clock, and reset SHALL be asynchronous and active-low.
REQ-007 Port i_aresetn, input, 1 bit: asynchronous active-low reset.
REQ-008 Port i_valid, input, 1 bit: i_prod carries a valid product this cycle.
REQ-009 Port i_prod, input, PROD_WIDTH bits: signed product (o_out of dsp_add).
REQ-010 Port i_clear, input, 1 bit: synchronous flush of all state.
REQ-011 Port i_ready, input, 1 bit: downstream accepts o_coef.
REQ-012 Port o_coef, output, OUT_WIDTH bits: signed rounded, saturated coefficient.
REQ-013 Port o_valid, output, 1 bit: o_coef holds an unaccepted coefficient.
REQ-014 Port o_index, output, 3 bits: DCT index (0..7) of the coefficient on o_coef.
REQ-015 Port o_busy, output, 1 bit: a partial sum is in progress (state ACCUM).
REQ-016 Port o_overflow, output, 1 bit: sticky; a completed coefficient was dropped.

Function
REQ-017 Accumulator width SHALL be PROD_WIDTH+$clog2(TERMS), signed, with sign-extended inputs and no internal wrap.
REQ-018 The FSM SHALL have two states: IDLE (term count 0) and ACCUM (1..TERMS-1 terms held).
REQ-019 IDLE + i_valid SHALL load acc=i_prod, set term count=1, and move to ACCUM (TERMS>1).
REQ-020 ACCUM + i_valid on a non-final term SHALL add i_prod and increment the term count.
REQ-021 ACCUM + i_valid on the final term (count==TERMS-1) SHALL form acc+i_prod and return to IDLE.
REQ-022 The final-term sum SHALL be registered into o_coef at that same edge, with o_valid=1 after the edge (one-cycle latency).
REQ-023 Rounding SHALL add 2^(FRAC_BITS-1), arithmetic-shift right FRAC_BITS, then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
REQ-024 o_valid && i_ready at an edge SHALL complete the transfer: o_valid clears, o_index increments, and 7 wraps to 0.
REQ-025 A completion with o_valid=1 and i_ready=0 SHALL drop the new result, keep o_coef/o_index unchanged, and set o_overflow.
REQ-026 A completion coinciding with an accepted transfer SHALL load the new result, keep o_valid=1, and not set o_overflow.
REQ-027 Cycles with i_valid=0 SHALL hold acc, term count and state unchanged (gaps allowed).
REQ-028 i_clear SHALL zero acc, term count, o_index, o_valid, o_coef and o_overflow and go to IDLE; it takes priority over a simultaneous i_valid, which is discarded.
REQ-029 o_busy SHALL equal (state==ACCUM).

Reset
REQ-030 While i_aresetn=0, all registers SHALL clear immediately: state=IDLE, acc=0, count=0, o_coef=0, o_valid=0, o_index=0, o_overflow=0, o_busy=0.
REQ-031 Reset asserted mid-ACCUM SHALL discard the partial sum, and the first i_valid after release SHALL start a new coefficient.

Structure
REQ-032 Package dct_pkg SHALL hold the default widths, TERMS, FRAC_BITS, the FSM state enum, and the OUT_WIDTH min/max saturation constants.
REQ-033 Rounding/saturation SHALL be one combinational sub-module, round_sat, parameterised by input width, FRAC_BITS and OUT_WIDTH.

Verification
REQ-034 Products 4096, 8192, 12288, 16384 (i_ready=1) -> o_coef=10, o_index=0, o_valid for 1 cycle.
REQ-035 Sums 2048 -> 1 and -2048 -> 0; four products of 2^40 -> 32767; four products of -2^40 -> -32768.
REQ-036 Eight back-to-back coefficients (i_ready=1) -> o_index 0..7 then 0, with gaps of i_valid=0 between terms giving identical results.
REQ-037 i_ready=0 across two completions -> the first result is held, the second is dropped, o_overflow=1; i_clear then zeros o_overflow, o_valid and o_index.
REQ-038 Reset after 2 of 4 terms, then 4 new products each 4096 -> o_coef=4, with no contribution from the pre-reset terms.
REQ-039 i_clear together with a final-term i_valid -> no o_valid, state IDLE, o_busy=0.
